// File: rtl/tpsnoop_pkg.sv
// ---------------------------------------------------------------------------
// tpsnoop_pkg
// Shared types and constants for the test-port write snooper.
//   state_t            : capture FSM states (IDLE, CAPT, DONE)
//   DEF_TEST_PORT_ADDR : default word address of the test port
//   DEF_BEGIN_SYM      : default word that opens capture (readable order)
//   DEF_END_SYM        : default word that closes capture (readable order)
//   bswap32()          : little-endian bus word -> readable order {b0,b1,b2,b3}
// ---------------------------------------------------------------------------
package tpsnoop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [29:0] DEF_TEST_PORT_ADDR = 30'h10;
  localparam logic [31:0] DEF_BEGIN_SYM      = 32'h00000168;
  localparam logic [31:0] DEF_END_SYM        = 32'hFFFFFD5D;

  // Byte 0 of the bus word becomes the most significant byte.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/tpsnoop_fifo.sv
// ---------------------------------------------------------------------------
// tpsnoop_fifo
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (clears contents too)
//   push         : write request, push_data is the word to store
//   pop          : head consumer ready; a pop only happens when not empty
//   push_ok      : this cycle's push is accepted (not full, or full with pop)
//   push_drop    : this cycle's push is discarded (full and no pop)
//   valid        : head entry present
//   head_data    : head entry, stable until popped
//   count        : occupancy, one extra bit separates full from empty
// Parameters: WIDTH (entry width), DEPTH (power of two, >= 2).
// ---------------------------------------------------------------------------
module tpsnoop_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   push_ok,
  output logic                   push_drop,
  output logic                   valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_pop_s;

  // Occupancy flags and the accept/drop decision for the current cycle
  always_comb begin
    empty_s   = (count_r == (AW+1)'(0));
    full_s    = (count_r == (AW+1)'(DEPTH));
    do_pop_s  = pop & ~empty_s;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push_ok   = push & (~full_s | do_pop_s);
    push_drop = push & full_s & ~do_pop_s;
  end

  // Entry storage; reset wipes stale contents as well as the pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid     = ~empty_s;
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/testport_write_snooper.sv
// ---------------------------------------------------------------------------
// testport_write_snooper
// Snoops CPU data-memory writes to the test port, collapses stalled writes
// into one event, byte-swaps the data and queues it for the result checker.
// Capture opens on BEGIN_SYM (not queued) and closes once END_SYM is queued.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   bus_addr/bus_wdata/bus_wen : snooped data-memory bus (little-endian data)
//   out_valid/out_data/out_ready : FIFO head towards the checker
//   fifo_count               : FIFO occupancy
//   capturing, end_seen      : FSM in CAPT / DONE
//   overflow                 : sticky, a word was dropped on a full FIFO
//   write_count, drop_count  : saturating counters of queued / dropped words
//   out_stamp                : only with TPSNOOP_TIMESTAMP_EN, cycle stamp of
//                              the head entry taken at its bus hit
// Optional feature macro: TPSNOOP_TIMESTAMP_EN.
// ---------------------------------------------------------------------------
module testport_write_snooper
  import tpsnoop_pkg::*;
#(
  parameter logic [29:0] TEST_PORT_ADDR = DEF_TEST_PORT_ADDR,
  parameter logic [31:0] BEGIN_SYM      = DEF_BEGIN_SYM,
  parameter logic [31:0] END_SYM        = DEF_END_SYM,
  parameter int          DEPTH          = 8,
  parameter int          CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [29:0]            bus_addr,
  input  logic [31:0]            bus_wdata,
  input  logic                   bus_wen,
  output logic                   out_valid,
  output logic [31:0]            out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   capturing,
  output logic                   end_seen,
  output logic                   overflow,
  output logic [CNT_W-1:0]       write_count,
`ifdef TPSNOOP_TIMESTAMP_EN
  output logic [CNT_W-1:0]       out_stamp,
`endif
  output logic [CNT_W-1:0]       drop_count
);

`ifdef TPSNOOP_TIMESTAMP_EN
  localparam int FW = 32 + CNT_W;
`else
  localparam int FW = 32;
`endif

  state_t           state_r;
  logic             armed_r;
  logic             hit_s;
  logic [31:0]      sw_s;
  // One-entry stage between the bus hit and the FIFO write.
  logic             pend_valid_r;
  logic [31:0]      pend_data_r;
  logic [FW-1:0]    fifo_in_s;
  logic [FW-1:0]    fifo_head_s;
  logic             push_ok_s;
  logic             push_drop_s;
  logic             capturing_r;
  logic             end_seen_r;
  logic             overflow_r;
  logic [CNT_W-1:0] write_count_r;
  logic [CNT_W-1:0] drop_count_r;

`ifdef TPSNOOP_TIMESTAMP_EN
  logic [CNT_W-1:0] stamp_cnt_r;
  logic [CNT_W-1:0] pend_stamp_r;
`endif

  // Bus hit qualification and readable-order data
  always_comb begin
    hit_s = bus_wen & (bus_addr == TEST_PORT_ADDR) & armed_r;
    sw_s  = bswap32(bus_wdata);
  end

  // Arm flag: one event per write-enable pulse however long a stall holds it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_r <= 1'b1;
    end else if (hit_s) begin
      armed_r <= 1'b0;
    end else if (!bus_wen) begin
      armed_r <= 1'b1;
    end
  end

  // Capture FSM with its pending-push stage and registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      pend_valid_r <= 1'b0;
      pend_data_r  <= 32'h0;
      capturing_r  <= 1'b0;
      end_seen_r   <= 1'b0;
    end else begin
      pend_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hit_s && (sw_s == BEGIN_SYM)) begin
            state_r     <= CAPT;
            capturing_r <= 1'b1;
          end
        end
        CAPT: begin
          if (hit_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= sw_s;
          end
          // Only a queued END_SYM closes capture; a dropped one does not.
          if (push_ok_s && (pend_data_r == END_SYM)) begin
            state_r     <= DONE;
            capturing_r <= 1'b0;
            end_seen_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r     <= IDLE;
          capturing_r <= 1'b0;
          end_seen_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow and saturating queued/dropped counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r    <= 1'b0;
      write_count_r <= {CNT_W{1'b0}};
      drop_count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s && (write_count_r != {CNT_W{1'b1}})) begin
        write_count_r <= write_count_r + CNT_W'(1);
      end
      if (push_drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != {CNT_W{1'b1}}) begin
          drop_count_r <= drop_count_r + CNT_W'(1);
        end
      end
    end
  end

`ifdef TPSNOOP_TIMESTAMP_EN
  // Free-running saturating cycle counter and the stamp taken at the hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_cnt_r  <= {CNT_W{1'b0}};
      pend_stamp_r <= {CNT_W{1'b0}};
    end else begin
      if (stamp_cnt_r != {CNT_W{1'b1}}) begin
        stamp_cnt_r <= stamp_cnt_r + CNT_W'(1);
      end
      if (hit_s) begin
        pend_stamp_r <= stamp_cnt_r;
      end
    end
  end

  assign fifo_in_s = {pend_stamp_r, pend_data_r};
  assign out_stamp = fifo_head_s[FW-1:32];
`else
  assign fifo_in_s = pend_data_r;
`endif

  tpsnoop_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_valid_r),
    .push_data (fifo_in_s),
    .pop       (out_ready),
    .push_ok   (push_ok_s),
    .push_drop (push_drop_s),
    .valid     (out_valid),
    .head_data (fifo_head_s),
    .count     (fifo_count)
  );

  assign out_data    = fifo_head_s[31:0];
  assign capturing   = capturing_r;
  assign end_seen    = end_seen_r;
  assign overflow    = overflow_r;
  assign write_count = write_count_r;
  assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_testport_write_snooper.sv
// ---------------------------------------------------------------------------
// tb_testport_write_snooper
// Directed scenarios followed by randomized bus traffic, every cycle compared
// against a queue-based behavioural model of the snooper.
// ---------------------------------------------------------------------------
module tb_testport_write_snooper;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam logic [31:0] BEGIN_W = 32'h00000168;
  localparam logic [31:0] END_W   = 32'hFFFFFD5D;
  localparam logic [29:0] PORT_A  = 30'h10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [29:0]       bus_addr = 30'h0;
  logic [31:0]       bus_wdata = 32'h0;
  logic              bus_wen = 1'b0;
  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_ready = 1'b0;
  logic [3:0]        fifo_count;
  logic              capturing;
  logic              end_seen;
  logic              overflow;
  logic [CNT_W-1:0]  write_count;
  logic [CNT_W-1:0]  drop_count;
`ifdef TPSNOOP_TIMESTAMP_EN
  logic [CNT_W-1:0]  out_stamp;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 capturing, 2 done.
  logic [31:0] mq[$];
  int          m_mode;
  bit          m_armed;
  bit          m_pend;
  logic [31:0] m_pend_w;
  bit          m_ovf;
  int          m_wc;
  int          m_dc;

  testport_write_snooper #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wen     (bus_wen),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .capturing   (capturing),
    .end_seen    (end_seen),
    .overflow    (overflow),
    .write_count (write_count),
`ifdef TPSNOOP_TIMESTAMP_EN
    .out_stamp   (out_stamp),
`endif
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] le_to_be(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_armed = 1'b1; m_pend = 1'b0; m_pend_w = 32'h0;
    m_ovf = 1'b0; m_wc = 0; m_dc = 0;
  endtask

  // Advance the model by one clock edge using the pre-edge inputs.
  task automatic model_edge();
    bit hit;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(m_pend_w);
        if (m_wc < 65535) m_wc++;
        if (m_pend_w == END_W) m_mode = 2;
      end else begin
        m_ovf = 1'b1;
        if (m_dc < 65535) m_dc++;
      end
      m_pend = 1'b0;
    end
    hit = bus_wen && (bus_addr == PORT_A) && m_armed;
    if (hit) begin
      m_armed = 1'b0;
      if (m_mode == 0 && le_to_be(bus_wdata) == BEGIN_W) m_mode = 1;
      else if (m_mode == 1) begin
        m_pend = 1'b1;
        m_pend_w = le_to_be(bus_wdata);
      end
    end else if (!bus_wen) begin
      m_armed = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", 64'(out_data), 64'(mq[0]));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("capturing", 64'(capturing), 64'(m_mode == 1));
    chk("end_seen", 64'(end_seen), 64'(m_mode == 2));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("write_count", 64'(write_count), 64'(m_wc));
    chk("drop_count", 64'(drop_count), 64'(m_dc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; bus_wen = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    bus_wen = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Write held for len cycles, then one cycle with write enable low.
  task automatic wr(input logic [29:0] a, input logic [31:0] d, input int len);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    for (int i = 0; i < len; i++) cycle();
    bus_wen = 1'b0;
    cycle();
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    bus_wen = 1'b0;
    for (int i = 0; i < budget && mq.size() > 0; i++) cycle();
    chk("drain_budget", 64'(mq.size()), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [31:0] rd;
`ifdef TPSNOOP_TIMESTAMP_EN
    logic [CNT_W-1:0] prev_stamp;
`endif
    model_reset();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    check_all();
    #6 rst = 1'b1;

    // T1: begin symbol, then one write held across a 4-cycle stall
    wr(PORT_A, 32'h68010000, 1);
    wr(PORT_A, 32'hADDE0000, 4);
    idle(1);
    chk("t1_capturing", 64'(capturing), 64'd1);
    chk("t1_count", 64'(fifo_count), 64'd1);
    chk("t1_data", 64'(out_data), 64'h0000DEAD);
    chk("t1_write_count", 64'(write_count), 64'd1);

    // T2: non-begin hit in IDLE and writes to another address in CAPT
    do_reset();
    wr(PORT_A, 32'hDEADBEEF, 1);
    chk("t2_idle_cap", 64'(capturing), 64'd0);
    wr(PORT_A, 32'h68010000, 2);
    wr(30'h14, 32'h11223344, 1);
    wr(30'h14, 32'h55667788, 3);
    idle(1);
    chk("t2_count", 64'(fifo_count), 64'd0);
    chk("t2_write_count", 64'(write_count), 64'd0);

    // T3: ten hits into an 8-deep FIFO, then drain in order
    for (int i = 0; i < 10; i++) wr(PORT_A, 32'(i + 1) << 8, 1);
    idle(1);
    chk("t3_count", 64'(fifo_count), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_drops", 64'(drop_count), 64'd2);
    out_ready = 1'b1;
`ifdef TPSNOOP_TIMESTAMP_EN
    prev_stamp = out_stamp;
`endif
    for (int i = 0; i < 8; i++) begin
      rd = 32'(i + 1) << 8;
      exp_w = le_to_be(rd);
      chk("t3_order", 64'(out_data), 64'(exp_w));
`ifdef TPSNOOP_TIMESTAMP_EN
      if (i > 0) chk("t3_stamp_inc", 64'(out_stamp > prev_stamp), 64'd1);
      prev_stamp = out_stamp;
`endif
      cycle();
    end
    out_ready = 1'b0;
    chk("t3_empty", 64'(out_valid), 64'd0);

    // T4: full FIFO, push lands in the same cycle as a pop
    for (int i = 0; i < 8; i++) wr(PORT_A, 32'hA0 + 32'(i), 1);
    chk("t4_full", 64'(fifo_count), 64'd8);
    bus_addr = PORT_A; bus_wdata = 32'hCAFEF00D; bus_wen = 1'b1;
    cycle();
    bus_wen = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("t4_count", 64'(fifo_count), 64'd8);
    chk("t4_drops", 64'(drop_count), 64'd2);
    chk("t4_tail", 64'(mq[7]), 64'h0DF0FECA);
    drain(12);

    // T5: end symbol queued, later hits ignored
    wr(PORT_A, 32'h5DFDFFFF, 1);
    chk("t5_data", 64'(out_data), 64'hFFFFFD5D);
    chk("t5_end_seen", 64'(end_seen), 64'd1);
    wr(PORT_A, 32'h12345678, 1);
    wr(PORT_A, 32'h68010000, 1);
    idle(1);
    chk("t5_count", 64'(fifo_count), 64'd1);
    drain(4);

    // T6: reset in the middle of a burst with three entries queued
    do_reset();
    wr(PORT_A, 32'h68010000, 1);
    for (int i = 0; i < 3; i++) wr(PORT_A, 32'h77000000 + 32'(i), 1);
    chk("t6_pre_count", 64'(fifo_count), 64'd3);
    do_reset();
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_capturing", 64'(capturing), 64'd0);
    chk("t6_write_count", 64'(write_count), 64'd0);

    // Randomized traffic: stalls, stray addresses, begin/end symbols
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        out_ready = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 2) == 0) begin
          bus_wen = 1'b0;
        end else if (!bus_wen || $urandom_range(0, 1) == 0) begin
          bus_wen = 1'b1;
          bus_addr = ($urandom_range(0, 4) == 0) ? 30'($urandom_range(0, 31)) : PORT_A;
          case ($urandom_range(0, 9))
            0, 1:    bus_wdata = 32'h68010000;
            2:       bus_wdata = ($urandom_range(0, 5) == 0) ? 32'h5DFDFFFF : $urandom;
            default: bus_wdata = $urandom;
          endcase
        end else begin
          bus_wen = 1'b1;
        end
        cycle();
      end
      drain(20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
